fpu_credit_scheduler: RTL and testbench
=======================================

Name: fpu_credit_scheduler

Overview:
Gates per-core APU requests in front of the shared-FPU request arbitration tree, and tracks in-flight operations against a fixed credit pool equal to the FPU pipeline capacity.
- Each core has at most one operation outstanding.
- Responses are steered back to the issuing core by one-hot ID.
- A flush FSM drains the FPU before a reconfiguration or clock-gate event.
- Placement: between the core APU ports and the arbitration tree; it observes the response bus.

Parameters:
- NB_CORES, 9, number of requesting cores.
- ID_WIDTH, NB_CORES, response ID width; the ID is one-hot, bit c = core c.
- CREDITS, 4, maximum operations in flight inside the FPU (range 1..15).
- CNT_WIDTH, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- core_req_i  in  NB_CORES  request from each core.
- core_gnt_o  out  NB_CORES  grant back to each core.
- arb_req_o  out  NB_CORES  gated requests into the arbitration tree.
- arb_gnt_i  in  NB_CORES  per-core grants from the arbitration tree.
- fpu_rvalid_i  in  1  FPU response valid.
- fpu_rID_i  in  ID_WIDTH  one-hot ID of the response.
- core_rvalid_o  out  NB_CORES  response valid steered to each core.
- flush_i  in  1  drain request, level-sensitive.
- flush_done_o  out  1  FPU empty and issue blocked.
- pending_o  out  NB_CORES  per-core outstanding bit.
- credits_o  out  CNT_WIDTH  free credits.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at a clk edge): all registered state is cleared.
  - credits=CREDITS, pending=0, state=RUN, err_o=0, flush_done_o=0.
  - All combinational outputs evaluate to 0 while the inputs are idle.
- Issue gating (combinational):
  - arb_req_o[c] = core_req_i[c] & ~pending[c] & (credits!=0) & (state==RUN).
  - core_gnt_o[c] = arb_gnt_i[c] & arb_req_o[c].
- Issue event: any core_gnt_o bit set. It sets pending[c] at the next edge and consumes one credit.
  - If more than one core_gnt_o bit is set in a cycle, set err_o.
  - In that case pending is set for every granted core, but only one credit is consumed.
- Response steering: core_rvalid_o = fpu_rID_i & {NB_CORES{fpu_rvalid_i}}, zero latency.
- Response accounting when fpu_rvalid_i=1:
  - Valid response (ID one-hot and pending[ID]=1): clear pending[ID] and return one credit.
  - Otherwise: set err_o, leave pending unchanged, return no credit.
- Simultaneous issue and valid response: credits unchanged, and both pending updates apply.
  - The same core cannot be both issued and retired in one cycle, because pending gates its issue.
- Credit saturation: credits never exceed CREDITS or drop below 0.
  - An attempted overflow sets err_o.
  - Underflow is impossible because issue is gated on credits!=0.
- Full pool (credits==0): all arb_req_o are low.
  - A response in the same cycle frees a credit, visible from the next cycle. There is no same-cycle bypass.
- Flush FSM, states RUN, DRAIN, FLUSHED:
  - RUN -> DRAIN when flush_i=1. Issue is blocked from the following cycle; a grant in the transition cycle is honoured.
  - DRAIN -> FLUSHED when credits==CREDITS and pending==0.
  - FLUSHED holds flush_done_o=1 (registered, asserted the cycle after entry).
  - FLUSHED -> RUN when flush_i=0. flush_done_o drops in the same edge.
  - flush_i deasserted while in DRAIN: remain in DRAIN until empty, then go to RUN without entering FLUSHED.
  - flush_i=1 while already empty in RUN: DRAIN for one cycle, then FLUSHED.
- err_o is sticky and is cleared only by rst.
- Reset mid-operation: all in-flight tracking is discarded.
  - Subsequent stale responses set err_o after reset. This is intended; the integrator resets the FPU together with this block.
- Outputs pending_o and credits_o are the registered state.

Decomposition:
- Package fpu_sched_pkg, containing:
  - enum sched_state_e {RUN, DRAIN, FLUSHED};
  - function is_onehot(logic [ID_WIDTH-1:0]);
  - a localparam default for CREDITS.
- No sub-module: credit counter, pending vector and FSM are small.
- The popcount/one-hot check lives in the package function, not a separate module.

Test Plan:
- Single issue/retire: core 3 req, arb_gnt_i=0x008 -> credits 4->3, pending_o=0x008. Then rvalid with rID=0x008 -> core_rvalid_o=0x008, credits 3, then 4 the next cycle, pending 0.
- Pool exhaustion: cores 0..4 requesting, tree grants one per cycle -> four grants, credits=0, arb_req_o=0 for core 4. Retire core 1 -> core 4 is granted exactly one cycle later.
- Per-core limit: core 2 holds req=1 after its grant -> arb_req_o[2]=0 until its response. No second issue occurs even with credits=3.
- Simultaneous issue and retire: grant core 5 and retire core 0 in the same cycle -> credits unchanged (2 stays 2), pending bit5 set and bit0 cleared.
- Flush: two ops in flight, flush_i=1 -> state DRAIN, no arb_req_o. After both responses, flush_done_o=1 one cycle after empty. Drop flush_i -> RUN, issue resumes.
- Errors: rvalid with rID=0x000, 0x003, or a non-pending core, and rst asserted mid-flight followed by a stale response -> err_o=1, credits unchanged, err_o held until the next rst.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// Shared types and helpers for the FPU credit scheduler.
//   sched_state_e    : flush FSM encoding (RUN, DRAIN, FLUSHED)
//   CREDITS_DEFAULT  : default FPU pipeline capacity
//   NB_CORES_DEFAULT : default number of requesting cores
//   is_onehot()      : true when exactly one bit of the argument is set
package fpu_sched_pkg;

  localparam int unsigned CREDITS_DEFAULT  = 4;
  localparam int unsigned NB_CORES_DEFAULT = 9;
  // is_onehot() takes a fixed-width argument; narrower IDs are zero-extended.
  localparam int unsigned MAX_ID_WIDTH     = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } sched_state_e;

  function automatic logic is_onehot(input logic [MAX_ID_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/fpu_credit_scheduler.sv
// Gates per-core APU requests in front of the shared-FPU arbitration tree and
// tracks in-flight operations against a fixed credit pool.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   core_req_i      : per-core requests
//   core_gnt_o      : per-core grants (tree grant qualified by gated request)
//   arb_req_o       : gated requests into the arbitration tree
//   arb_gnt_i       : per-core grants from the arbitration tree
//   fpu_rvalid_i    : FPU response valid
//   fpu_rID_i       : one-hot ID of the response
//   core_rvalid_o   : response valid steered to the issuing core
//   flush_i         : level-sensitive drain request
//   flush_done_o    : FPU empty and issue blocked
//   pending_o       : per-core outstanding bit
//   credits_o       : free credits
//   err_o           : sticky protocol error
module fpu_credit_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NB_CORES  = NB_CORES_DEFAULT,
  parameter int unsigned ID_WIDTH  = NB_CORES,
  parameter int unsigned CREDITS   = CREDITS_DEFAULT,
  parameter int unsigned CNT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NB_CORES-1:0]  core_req_i,
  output logic [NB_CORES-1:0]  core_gnt_o,
  output logic [NB_CORES-1:0]  arb_req_o,
  input  logic [NB_CORES-1:0]  arb_gnt_i,
  input  logic                 fpu_rvalid_i,
  input  logic [ID_WIDTH-1:0]  fpu_rID_i,
  output logic [NB_CORES-1:0]  core_rvalid_o,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic [NB_CORES-1:0]  pending_o,
  output logic [CNT_WIDTH-1:0] credits_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CREDITS_FULL = CNT_WIDTH'(CREDITS);

  sched_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] credits_q, credits_d;
  logic [NB_CORES-1:0] pending_q, pending_d;
  logic                err_q, err_d;
  logic                flush_done_q, flush_done_d;

  logic                can_issue;
  logic                issue;
  logic                multi_gnt;
  logic                rsp_ok;
  logic                pool_empty;

  assign can_issue  = (credits_q != '0) && (state_q == RUN);
  assign arb_req_o  = core_req_i & ~pending_q & {NB_CORES{can_issue}};
  assign core_gnt_o = arb_gnt_i & arb_req_o;

  assign issue      = |core_gnt_o;
  assign multi_gnt  = (core_gnt_o & (core_gnt_o - NB_CORES'(1))) != '0;

  assign core_rvalid_o = NB_CORES'(fpu_rID_i) & {NB_CORES{fpu_rvalid_i}};

  // A response only retires if it names exactly one core that is outstanding.
  assign rsp_ok = fpu_rvalid_i
                  && is_onehot(MAX_ID_WIDTH'(fpu_rID_i))
                  && ((NB_CORES'(fpu_rID_i) & pending_q) != '0);

  assign pool_empty = (credits_q == CREDITS_FULL) && (pending_q == '0);

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    err_d     = err_q;
    pending_d = pending_q | core_gnt_o;

    if (rsp_ok) begin
      pending_d = pending_d & ~NB_CORES'(fpu_rID_i);
    end
    if ((fpu_rvalid_i && !rsp_ok) || multi_gnt) begin
      err_d = 1'b1;
    end

    // A multi-grant still consumes only one credit.
    case ({issue, rsp_ok})
      2'b10: credits_d = credits_q - CNT_WIDTH'(1);
      2'b01: begin
        if (credits_q == CREDITS_FULL) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase

    case (state_q)
      RUN: begin
        if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        // A flush withdrawn mid-drain returns straight to RUN once empty.
        if (pool_empty) state_d = flush_i ? FLUSHED : RUN;
      end
      FLUSHED: begin
        if (!flush_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    flush_done_d = (state_d == FLUSHED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      credits_q    <= CREDITS_FULL;
      pending_q    <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign pending_o    = pending_q;
  assign credits_o    = credits_q;
  assign err_o        = err_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_fpu_credit_scheduler.sv
// Directed bench for fpu_credit_scheduler. Steered responses are checked by a
// scoreboard monitor; registered state and gating are checked inline.
module tb_fpu_credit_scheduler;

  localparam int NB = 9;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] core_req_i, arb_gnt_i, fpu_rID_i;
  logic          fpu_rvalid_i, flush_i;
  logic [NB-1:0] core_gnt_o, arb_req_o, core_rvalid_o, pending_o;
  logic          flush_done_o, err_o;
  logic [CW-1:0] credits_o;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];

  fpu_credit_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .core_req_i   (core_req_i),
    .core_gnt_o   (core_gnt_o),
    .arb_req_o    (arb_req_o),
    .arb_gnt_i    (arb_gnt_i),
    .fpu_rvalid_i (fpu_rvalid_i),
    .fpu_rID_i    (fpu_rID_i),
    .core_rvalid_o(core_rvalid_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .pending_o    (pending_o),
    .credits_o    (credits_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every nonzero steered response must match the queue head.
  always @(negedge clk) begin
    if (core_rvalid_o != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got %h, expected nothing", core_rvalid_o);
      end else begin
        logic [NB-1:0] e;
        e = exp_q.pop_front();
        if (core_rvalid_o !== e) begin
          errors++;
          $display("FAIL rvalid_steer: got %h, expected %h", core_rvalid_o, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req_i   = '0;
    arb_gnt_i    = '0;
    fpu_rvalid_i = 1'b0;
    fpu_rID_i    = '0;
  endtask

  task automatic do_reset();
    idle();
    flush_i = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic grant(input logic [NB-1:0] c);
    core_req_i = c;
    arb_gnt_i  = c;
    cyc();
    core_req_i = '0;
    arb_gnt_i  = '0;
  endtask

  // Retire a core and register the steered response it must produce.
  task automatic retire(input logic [NB-1:0] id);
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = id;
    if (id != '0) exp_q.push_back(id);
    cyc();
    fpu_rvalid_i = 1'b0;
    fpu_rID_i    = '0;
  endtask

  initial begin
    idle();
    flush_i = 1'b0;
    rst = 1'b1;
    do_reset();

    // Reset state
    #1;
    chk("rst_credits", 32'(credits_o), 4);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_flush_done", 32'(flush_done_o), 0);
    chk("rst_arb_req", 32'(arb_req_o), 0);
    chk("rst_core_gnt", 32'(core_gnt_o), 0);

    // Single issue / retire on core 3
    core_req_i = 9'h008; arb_gnt_i = 9'h008; #1;
    chk("single_arb_req", 32'(arb_req_o), 32'h008);
    chk("single_gnt", 32'(core_gnt_o), 32'h008);
    cyc(); idle();
    chk("single_credits_after_issue", 32'(credits_o), 3);
    chk("single_pending", 32'(pending_o), 32'h008);
    fpu_rvalid_i = 1'b1; fpu_rID_i = 9'h008; exp_q.push_back(9'h008); #1;
    chk("single_credits_rsp_cycle", 32'(credits_o), 3);
    cyc(); idle();
    chk("single_credits_retired", 32'(credits_o), 4);
    chk("single_pending_retired", 32'(pending_o), 0);

    // Pool exhaustion: cores 0..4 requesting, one grant per cycle
    core_req_i = 9'h01F;
    for (int i = 0; i < 4; i++) begin
      arb_gnt_i = 9'(1 << i);
      cyc();
      chk("exh_credits", 32'(credits_o), 32'(3 - i));
    end
    arb_gnt_i = 9'h010; #1;
    chk("exh_arb_req_full", 32'(arb_req_o), 0);
    chk("exh_pending", 32'(pending_o), 32'h00F);
    core_req_i = 9'h010;
    fpu_rvalid_i = 1'b1; fpu_rID_i = 9'h002; exp_q.push_back(9'h002); #1;
    chk("exh_no_bypass_gnt", 32'(core_gnt_o), 0);
    cyc();
    fpu_rvalid_i = 1'b0; fpu_rID_i = '0; #1;
    chk("exh_credit_freed", 32'(credits_o), 1);
    chk("exh_core4_arb_req", 32'(arb_req_o), 32'h010);
    chk("exh_core4_gnt", 32'(core_gnt_o), 32'h010);
    cyc(); idle();
    chk("exh_credits_zero", 32'(credits_o), 0);
    chk("exh_pending2", 32'(pending_o), 32'h01D);
    retire(9'h001); retire(9'h004); retire(9'h008); retire(9'h010);
    chk("exh_drained_credits", 32'(credits_o), 4);
    chk("exh_drained_pending", 32'(pending_o), 0);

    // Per-core limit: core 2 keeps requesting after its grant
    core_req_i = 9'h004; arb_gnt_i = 9'h004;
    cyc(); #1;
    chk("limit_arb_req", 32'(arb_req_o), 0);
    chk("limit_gnt", 32'(core_gnt_o), 0);
    cyc(); cyc();
    chk("limit_credits", 32'(credits_o), 3);
    chk("limit_pending", 32'(pending_o), 32'h004);
    fpu_rvalid_i = 1'b1; fpu_rID_i = 9'h004; exp_q.push_back(9'h004); #1;
    chk("limit_arb_req_rsp_cycle", 32'(arb_req_o), 0);
    cyc();
    fpu_rvalid_i = 1'b0; fpu_rID_i = '0; #1;
    chk("limit_arb_req_released", 32'(arb_req_o), 32'h004);
    idle(); #1;
    cyc();
    chk("limit_credits_back", 32'(credits_o), 4);

    // Simultaneous issue (core 5) and retire (core 0)
    grant(9'h001); grant(9'h002);
    chk("sim_credits_pre", 32'(credits_o), 2);
    core_req_i = 9'h020; arb_gnt_i = 9'h020;
    fpu_rvalid_i = 1'b1; fpu_rID_i = 9'h001; exp_q.push_back(9'h001);
    cyc(); idle();
    chk("sim_credits", 32'(credits_o), 2);
    chk("sim_pending", 32'(pending_o), 32'h022);
    retire(9'h002); retire(9'h020);
    chk("sim_credits_back", 32'(credits_o), 4);

    // Flush with ops in flight, grant honoured in the transition cycle
    grant(9'h040); grant(9'h080);
    core_req_i = 9'h100; arb_gnt_i = 9'h100; flush_i = 1'b1; #1;
    chk("flush_transition_gnt", 32'(core_gnt_o), 32'h100);
    cyc();
    core_req_i = 9'h001; arb_gnt_i = 9'h001; #1;
    chk("flush_credits", 32'(credits_o), 1);
    chk("drain_arb_req", 32'(arb_req_o), 0);
    chk("drain_flush_done", 32'(flush_done_o), 0);
    retire(9'h040);
    core_req_i = 9'h001; arb_gnt_i = 9'h001;
    retire(9'h080);
    core_req_i = 9'h001; arb_gnt_i = 9'h001;
    retire(9'h100);
    core_req_i = 9'h001; arb_gnt_i = 9'h001; #1;
    chk("drain_empty_credits", 32'(credits_o), 4);
    chk("drain_empty_done", 32'(flush_done_o), 0);
    chk("drain_empty_arb_req", 32'(arb_req_o), 0);
    cyc();
    chk("flushed_done", 32'(flush_done_o), 1);
    chk("flushed_arb_req", 32'(arb_req_o), 0);
    cyc();
    chk("flushed_hold", 32'(flush_done_o), 1);
    flush_i = 1'b0;
    cyc();
    chk("unflush_done", 32'(flush_done_o), 0);
    chk("unflush_arb_req", 32'(arb_req_o), 32'h001);
    cyc(); idle();
    retire(9'h001);
    chk("flush_err", 32'(err_o), 0);

    // Flush withdrawn during DRAIN: back to RUN without FLUSHED
    grant(9'h008);
    flush_i = 1'b1; cyc();
    flush_i = 1'b0; core_req_i = 9'h002; #1;
    chk("wd_drain_arb_req", 32'(arb_req_o), 0);
    cyc();
    retire(9'h008);
    core_req_i = 9'h002; #1;
    chk("wd_still_drain", 32'(arb_req_o), 0);
    cyc();
    chk("wd_no_flushed", 32'(flush_done_o), 0);
    chk("wd_run_arb_req", 32'(arb_req_o), 32'h002);
    idle();
    chk("wd_err", 32'(err_o), 0);

    // Errors: zero ID
    retire(9'h000);
    chk("err_zero_id", 32'(err_o), 1);
    chk("err_zero_id_credits", 32'(credits_o), 4);
    do_reset();
    chk("err_cleared_by_rst", 32'(err_o), 0);

    // Errors: multi-hot ID while both cores pending
    grant(9'h001); grant(9'h002);
    retire(9'h003);
    chk("err_multihot", 32'(err_o), 1);
    chk("err_multihot_credits", 32'(credits_o), 2);
    chk("err_multihot_pending", 32'(pending_o), 32'h003);
    do_reset();

    // Errors: response for non-pending core
    retire(9'h010);
    chk("err_nonpending", 32'(err_o), 1);
    chk("err_nonpending_credits", 32'(credits_o), 4);
    do_reset();

    // Reset mid-flight, then stale response
    grant(9'h004);
    chk("midrst_pre_credits", 32'(credits_o), 3);
    do_reset();
    chk("midrst_credits", 32'(credits_o), 4);
    chk("midrst_pending", 32'(pending_o), 0);
    retire(9'h004);
    chk("stale_err", 32'(err_o), 1);
    chk("stale_credits", 32'(credits_o), 4);
    cyc(); cyc(); cyc();
    chk("err_sticky", 32'(err_o), 1);
    do_reset();

    // Multi-grant: both pending, one credit, then overflow on second retire
    core_req_i = 9'h003; arb_gnt_i = 9'h003;
    cyc(); idle();
    chk("multi_err", 32'(err_o), 1);
    chk("multi_pending", 32'(pending_o), 32'h003);
    chk("multi_credits", 32'(credits_o), 3);
    retire(9'h001);
    chk("multi_ret0_credits", 32'(credits_o), 4);
    retire(9'h002);
    chk("overflow_credits", 32'(credits_o), 4);
    chk("overflow_pending", 32'(pending_o), 0);

    @(negedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
